// File: rtl/m_mult_pipe_if.sv
// Operand/result bundle for m_mult_pipe.
// Handshake: a beat moves in when i_valid && o_ready. A beat moves out when
// o_valid && i_ready. A producer holds its valid and data steady until the
// transfer happens. o_ready may depend combinationally on i_ready.
interface m_mult_pipe_if #(
    parameter int N     = 16,
    parameter int LANES = 16
);
    logic               i_valid;
    logic               o_ready;
    logic [LANES*N-1:0] i_A;
    logic [LANES*N-1:0] i_B;
    logic               i_round;
    logic               o_valid;
    logic               i_ready;
    logic [LANES*N-1:0] o_C;
    logic [LANES-1:0]   o_sat;

    // Multiplier side.
    modport slave (
        input  i_valid, i_A, i_B, i_round, i_ready,
        output o_ready, o_valid, o_C, o_sat
    );

    // Producer/consumer side.
    modport master (
        output i_valid, i_A, i_B, i_round, i_ready,
        input  o_ready, o_valid, o_C, o_sat
    );
endinterface

// File: rtl/m_mult_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier (Qm.Q, N-bit lanes).
// Stage 0 registers the full 2N-bit products. Later stages are plain
// registers. Rounding and narrowing are applied to the last stage's contents.
// The MULT_SAT_EN macro selects saturating narrowing; when it is undefined,
// results wrap and o_sat is tied low.
module m_mult_pipe #(
    parameter int N      = 16,
    parameter int Q      = 10,
    parameter int LANES  = 16,
    parameter int STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    m_mult_pipe_if.slave  bus
);

    localparam int PW   = 2 * N;
    localparam int LAST = STAGES - 1;
    localparam int RSH  = (Q > 0) ? Q - 1 : 0;
    localparam logic signed [PW-1:0] HALF = (Q > 0) ? (PW'(1) << RSH) : '0;

`ifdef MULT_SAT_EN
    localparam logic signed [PW-1:0] MAX_R = {{(PW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_R = {{(PW-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [N-1:0]         MAX_C = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]         MIN_C = {1'b1, {(N-1){1'b0}}};
`endif

    logic [STAGES-1:0]   v_q;
    logic [STAGES-1:0]   rnd_q;
    logic [LANES*PW-1:0] prod_q [STAGES];
    logic [LANES*PW-1:0] prod_d;
    logic [STAGES-1:0]   en;
    logic [LANES*N-1:0]  c_d;
    logic [LANES-1:0]    sat_d;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] r;
    logic                 free;

    // Full-width signed product of every lane, ready to load into stage 0.
    always_comb begin
        prod_d = '0;
        a_x    = '0;
        b_x    = '0;
        for (int k = 0; k < LANES; k++) begin
            a_x = PW'($signed(bus.i_A[k*N +: N]));
            b_x = PW'($signed(bus.i_B[k*N +: N]));
            prod_d[k*PW +: PW] = a_x * b_x;
        end
    end

    // Stage s may load when it or any stage after it has a free slot, or the
    // consumer is taking the output beat this cycle.
    always_comb begin
        en   = '0;
        free = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            free = bus.i_ready;
            for (int j = s; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    free = 1'b1;
                end
            end
            en[s] = free;
        end
    end

    // Pipeline registers. Valid and the round flag travel with each beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            rnd_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s] <= '0;
            end
        end else begin
            if (en[0]) begin
                v_q[0]    <= bus.i_valid;
                rnd_q[0]  <= bus.i_round;
                prod_q[0] <= prod_d;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (en[s]) begin
                    v_q[s]    <= v_q[s-1];
                    rnd_q[s]  <= rnd_q[s-1];
                    prod_q[s] <= prod_q[s-1];
                end
            end
        end
    end

    // Round, shift down by Q, then narrow to N bits for every lane.
    always_comb begin
        c_d   = '0;
        sat_d = '0;
        p     = '0;
        pr    = '0;
        r     = '0;
        for (int k = 0; k < LANES; k++) begin
            p  = prod_q[LAST][k*PW +: PW];
            pr = p + (rnd_q[LAST] ? HALF : '0);
            r  = pr >>> Q;
`ifdef MULT_SAT_EN
            if (r > MAX_R) begin
                c_d[k*N +: N] = MAX_C;
                sat_d[k]      = 1'b1;
            end else if (r < MIN_R) begin
                c_d[k*N +: N] = MIN_C;
                sat_d[k]      = 1'b1;
            end else begin
                c_d[k*N +: N] = r[N-1:0];
            end
`else
            c_d[k*N +: N] = r[N-1:0];
`endif
        end
    end

    assign bus.o_ready = en[0];
    assign bus.o_valid = v_q[LAST];
    assign bus.o_C     = c_d;
    assign bus.o_sat   = sat_d;

endmodule

// File: tb/tb_m_mult_pipe.sv
// Bench for m_mult_pipe: directed cases, back-pressure, reset and random
// traffic. Results are compared against an arithmetic model through a
// scoreboard queue.
module tb_m_mult_pipe;

    localparam int N      = 16;
    localparam int Q      = 10;
    localparam int LANES  = 16;
    localparam int STAGES = 2;
    localparam int W      = LANES * N;

    logic clk;
    logic rst;

    m_mult_pipe_if #(.N(N), .LANES(LANES)) bus ();

    m_mult_pipe #(.N(N), .Q(Q), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0]     exp_q[$];
    logic [LANES-1:0] exp_sat_q[$];
    int               checks;
    int               errors;
    int               emitted;
    logic             last_acc;
    logic             last_ovalid;
    logic             last_oready;
    logic [W-1:0]     last_c;
    logic [LANES-1:0] last_sat;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic per lane.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic rnd,
                                  output logic [W-1:0] c, output logic [LANES-1:0] s);
        longint p;
        longint r;
        longint maxv;
        longint minv;
        logic [63:0] rb;
        maxv = (longint'(1) << (N - 1)) - 1;
        minv = -(longint'(1) << (N - 1));
        c = '0;
        s = '0;
        for (int k = 0; k < LANES; k++) begin
            p = longint'($signed(a[k*N +: N])) * longint'($signed(b[k*N +: N]));
            if (rnd && Q > 0) p = p + (longint'(1) << (Q - 1));
            r  = p >>> Q;
            rb = r;
`ifdef MULT_SAT_EN
            if (r > maxv) begin
                rb = maxv;
                s[k] = 1'b1;
            end else if (r < minv) begin
                rb = minv;
                s[k] = 1'b1;
            end
`endif
            c[k*N +: N] = rb[N-1:0];
        end
    endfunction

    // One clock: observe at negedge, update scoreboard, advance past posedge.
    task automatic step();
        logic [W-1:0]     ec;
        logic [LANES-1:0] es;
        logic             acc;
        logic             emit;
        @(negedge clk);
        acc         = bus.i_valid && bus.o_ready && !rst;
        emit        = bus.o_valid && bus.i_ready && !rst;
        last_acc    = acc;
        last_ovalid = bus.o_valid;
        last_oready = bus.o_ready;
        last_c      = bus.o_C;
        last_sat    = bus.o_sat;
        if (bus.o_valid && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", W'(bus.o_valid), '0);
            end else begin
                check("data", bus.o_C, exp_q[0]);
                check("sat", W'(bus.o_sat), W'(exp_sat_q[0]));
            end
        end
        if (emit && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
            emitted++;
        end
        if (acc) begin
            model(bus.i_A, bus.i_B, bus.i_round, ec, es);
            exp_q.push_back(ec);
            exp_sat_q.push_back(es);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_sat_q.delete();
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.i_valid = 1'b0;
        bus.i_A     = '0;
        bus.i_B     = '0;
        bus.i_round = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Send one beat, then wait for it at the output; returns latency in cycles.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic rnd, output int lat);
        int budget;
        bus.i_A     = a;
        bus.i_B     = b;
        bus.i_round = rnd;
        bus.i_valid = 1'b1;
        budget      = 0;
        step();
        while (!last_acc && budget < 20) begin
            step();
            budget++;
        end
        bus.i_valid = 1'b0;
        lat = 1;
        step();
        while (!last_ovalid && lat < 20) begin
            lat++;
            step();
        end
        if (!last_ovalid) check("timeout_one", '0, W'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        int           idx;
        int           e0;
        int           budget;
        logic         saw_block;
        logic [15:0]  ovf0;
        logic [15:0]  ovf1;
        logic [W-1:0] sat_exp;

        checks  = 0;
        errors  = 0;
        emitted = 0;
        rst     = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_ovalid", W'(bus.o_valid), '0);
        check("rst_oc", bus.o_C, '0);
        check("rst_osat", W'(bus.o_sat), '0);
        check("rst_oready", W'(bus.o_ready), W'(1));

        // Basic products and latency.
        a = '0; b = '0;
        a[15:0] = 16'h0600; b[15:0] = 16'h0800;
        a[31:16] = 16'hFC00; b[31:16] = 16'h0200;
        run_one(a, b, 1'b0, lat);
        check("latency", W'(lat), W'(STAGES));
        check("basic_l0", W'(last_c[15:0]), W'(16'h0C00));
        check("basic_l1", W'(last_c[31:16]), W'(16'hFE00));
        check("basic_sat", W'(last_sat), '0);

        // Rounding: truncate vs half-up, positive and negative.
        a = '0; b = '0;
        a[15:0] = 16'h0001; b[15:0] = 16'h0200;
        a[31:16] = 16'hFFFF; b[31:16] = 16'h0200;
        run_one(a, b, 1'b0, lat);
        check("trunc_l0", W'(last_c[15:0]), W'(16'h0000));
        check("trunc_l1", W'(last_c[31:16]), W'(16'hFFFF));
        run_one(a, b, 1'b1, lat);
        check("round_l0", W'(last_c[15:0]), W'(16'h0001));
        check("round_l1", W'(last_c[31:16]), W'(16'h0000));

        // Overflow corners.
        a = '0; b = '0;
        a[15:0] = 16'h7FFF; b[15:0] = 16'h7FFF;
        a[31:16] = 16'h8000; b[31:16] = 16'h8000;
        run_one(a, b, 1'b0, lat);
`ifdef MULT_SAT_EN
        ovf0 = 16'h7FFF; ovf1 = 16'h7FFF; sat_exp = W'(2'b11);
`else
        ovf0 = 16'hFFC0; ovf1 = 16'h0000; sat_exp = '0;
`endif
        check("ovf_l0", W'(last_c[15:0]), W'(ovf0));
        check("ovf_l1", W'(last_c[31:16]), W'(ovf1));
        check("ovf_sat", W'(last_sat), sat_exp);

        // Back-pressure: 6 beats, consumer stalls on cycles 3..5.
        e0 = emitted; idx = 0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.i_ready = !(cyc >= 3 && cyc <= 5);
            bus.i_valid = (idx < 6);
            for (int k = 0; k < LANES; k++) begin
                bus.i_A[k*N +: N] = 16'(16'h0400 + idx * 16'h0100 + k);
                bus.i_B[k*N +: N] = 16'(16'h0400 + k);
            end
            bus.i_round = idx[0];
            step();
            if (bus.i_valid && !last_oready) saw_block = 1'b1;
            if (last_acc) idx++;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        check("bp_accepted", W'(idx), W'(6));
        check("bp_emitted", W'(emitted - e0), W'(6));
        check("bp_block", W'(saw_block), W'(1));

        // Reset with two beats in flight.
        bus.i_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            bus.i_A[k*N +: N] = 16'($urandom);
            bus.i_B[k*N +: N] = 16'($urandom);
        end
        step();
        step();
        bus.i_valid = 1'b0;
        do_reset();
        check("mrst_ovalid", W'(bus.o_valid), '0);
        check("mrst_oc", bus.o_C, '0);
        check("mrst_osat", W'(bus.o_sat), '0);
        check("mrst_oready", W'(bus.o_ready), W'(1));
        e0 = emitted;
        repeat (6) step();
        check("mrst_no_stale", W'(emitted - e0), '0);

        // Lane independence: small operands everywhere, lane 7 overflows.
        for (int k = 0; k < LANES; k++) begin
            a[k*N +: N] = 16'($urandom_range(0, 4095) - 2048);
            b[k*N +: N] = 16'($urandom_range(0, 4095) - 2048);
        end
        a[7*N +: N] = 16'h7FFF;
        b[7*N +: N] = 16'h7FFF;
        run_one(a, b, 1'($urandom_range(0, 1)), lat);
`ifdef MULT_SAT_EN
        sat_exp = W'(16'h0080);
`else
        sat_exp = '0;
`endif
        check("lane_sat", W'(last_sat), sat_exp);

        // Random traffic with random stalls.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.i_valid || last_acc) begin
                bus.i_valid = ($urandom_range(0, 9) < 7);
                for (int k = 0; k < LANES; k++) begin
                    bus.i_A[k*N +: N] = 16'($urandom);
                    bus.i_B[k*N +: N] = 16'($urandom);
                end
                bus.i_round = 1'($urandom_range(0, 1));
            end
            bus.i_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain.
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            step();
            budget++;
        end
        check("drain", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_mult_pipe.md
# m_mult_pipe

Parametrised, pipelined, multi-lane fixed-point multiplier: the next-generation replacement for the single-lane combinational fixed-point multiplier used in the NFU datapath. It multiplies LANES independent pairs of signed Qm.Q operands per beat, with selectable rounding and optional saturation. A valid/ready handshake with full back-pressure lets it sit directly between the synapse/neuron operand buffers and the adder tree.

## Interface
- N, 16: operand and result width (two's complement), 4..32
- Q, 10: fractional bits, 0..N-1
- LANES, 16: parallel multiplier lanes
- STAGES, 2: pipeline register stages, >=1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  input beat present
- o_ready  output  1  block accepts input this cycle
- i_A  input  LANES*N  operand A; lane k at [k*N +: N]
- i_B  input  LANES*N  operand B; same packing
- i_round  input  1  1 = round half-up, 0 = truncate (floor); sampled with the beat
- o_valid  output  1  output beat present
- i_ready  input  1  downstream accepts output
- o_C  output  LANES*N  results; same packing
- o_sat  output  LANES  per-lane saturation flag, aligned with o_C

## Operation
- Per lane: P = A*B, full 2N-bit signed product.
- Rounding: if i_round and Q>0, P' = P + 2^(Q-1), else P' = P. Then R = P' >>> Q (arithmetic shift, floor).
- Narrowing to N bits: see Configuration.
- Beat transfer in: i_valid && o_ready. Beat transfer out: o_valid && i_ready.
- Each stage s holds a valid bit v[s] plus data; i_round travels with its beat.
- Stage s advances when v[s]=0 on the stage it feeds, or that stage advances; last stage advances when i_ready or !o_valid.
- o_ready = !v[0] || stage 0 advances (combinational from i_ready allowed).
- No beat dropped, duplicated, or reordered; lanes never interact.
- While o_valid && !i_ready: o_C, o_sat held stable.
- Reset: all v[] cleared; o_valid=0, o_C=0, o_sat=0; o_ready=1 on the first cycle after rst deasserts. Reset mid-stream discards in-flight beats.

## Timing
- Latency: STAGES cycles from accept edge to o_valid, with no stall.
- Throughput: one beat/cycle while i_ready=1.
- Capacity: STAGES beats; with i_ready=0 and all stages full, o_ready=0.
- Simultaneous accept and emit on a full pipe: both occur, occupancy unchanged.
- Product computed in stage 0; rounding and narrowing in the final stage. Intermediate stages are pure registers.

## Configuration
- MULT_SAT_EN defined: if R > 2^(N-1)-1, o_C = 2^(N-1)-1. If R < -2^(N-1), o_C = -2^(N-1). In either case o_sat[k]=1; otherwise o_C = R[N-1:0] and o_sat[k]=0.
- MULT_SAT_EN undefined: o_C = R[N-1:0] (wrap); o_sat tied to 0; no comparison logic synthesised.

## Test plan
- Defaults, i_round=0: lane0 0x0600 (1.5) * 0x0800 (2.0) -> o_C lane0 0x0C00 after exactly 2 cycles. Lane1 0xFC00 (-1.0) * 0x0200 (0.5) -> 0xFE00, o_sat=0.
- Rounding: 0x0001 * 0x0200 (2^-11 product): i_round=0 -> 0x0000; i_round=1 -> 0x0001. 0xFFFF * 0x0200: i_round=0 -> 0xFFFF; i_round=1 -> 0x0000.
- Overflow 0x7FFF * 0x7FFF and 0x8000 * 0x8000: with MULT_SAT_EN -> 0x7FFF, o_sat=1 for both. Without it -> 0xFFC0 and 0x0000, o_sat=0.
- Back-pressure, STAGES=2: stream 6 distinct beats with i_valid=1; hold i_ready=0 for cycles 3-5. Required: o_ready=0 once 2 beats are held, o_C stable while stalled, all 6 results in order, none lost.
- Reset mid-stream: 2 beats in flight, rst=1 for 1 cycle. Required: o_valid=0, o_C=0, o_sat=0 next cycle, o_ready=1, and no stale beat emitted afterwards.
- Lane independence, LANES=16: random operands on every lane with one lane overflowing. Required: only that lane's o_sat set; all lanes match the reference model.
